// File: rtl/condlogic_it_if.sv
// Execute-stage condition bus: unconditioned requests and flags in, gated requests
// and IT/flag status out.
interface condlogic_it_if #(
  parameter int LANES  = 1,
  parameter int IT_MAX = 4
);
  localparam int ITW = $clog2(IT_MAX + 1);

  logic                 StallE;
  logic                 FlushE;
  logic [3:0]           CondE;
  logic [1:0]           FlagWriteE;
  logic [4*LANES-1:0]   ALUFlagsE;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic                 PCSrcE;
  logic                 ItStartE;
  logic [3:0]           ItCondE;
  logic [IT_MAX-1:0]    ItMaskE;
  logic [ITW-1:0]       ItLenE;

  logic [LANES-1:0]     CondExE;
  logic [LANES-1:0]     RegWriteGE;
  logic                 MemWriteGE;
  logic                 PCSrcGE;
  logic [4*LANES-1:0]   FlagsQ;
  logic                 ItActive;
  logic [ITW-1:0]       ItRemaining;

  modport master (
    output StallE, FlushE, CondE, FlagWriteE, ALUFlagsE, RegWriteE, MemWriteE,
           PCSrcE, ItStartE, ItCondE, ItMaskE, ItLenE,
    input  CondExE, RegWriteGE, MemWriteGE, PCSrcGE, FlagsQ, ItActive, ItRemaining
  );

  modport slave (
    input  StallE, FlushE, CondE, FlagWriteE, ALUFlagsE, RegWriteE, MemWriteE,
           PCSrcE, ItStartE, ItCondE, ItMaskE, ItLenE,
    output CondExE, RegWriteGE, MemWriteGE, PCSrcGE, FlagsQ, ItActive, ItRemaining
  );
endinterface

// File: rtl/condlogic_it.sv
// Execute-stage condition unit: per-lane NZCV registers, ARM condition evaluation,
// write/branch gating and an IT-block sequencer.
module condlogic_it #(
  parameter int LANES  = 1,
  parameter int IT_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  condlogic_it_if.slave bus
);
  localparam int ITW = $clog2(IT_MAX + 1);

  logic [4*LANES-1:0] flags_q;
  logic [ITW-1:0]     it_count;
  logic [IT_MAX-1:0]  it_mask;
  logic [3:0]         it_cond;

  logic               it_active;
  logic               advance;
  logic [3:0]         cond_eff;
  logic [LANES-1:0]   cond_ex;
  logic [LANES-1:0]   reg_g;
  logic               mem_g;
  logic               pc_g;
  logic [ITW-1:0]     it_len_sat;

  // flags order {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = ~cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = cf & ~z;
      4'b1001: cond_pass = ~cf | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  always_comb begin
    it_active = |it_count;
    advance   = ~bus.StallE & ~bus.FlushE;
    cond_eff  = it_active ? (it_mask[0] ? it_cond : (it_cond ^ 4'b0001)) : bus.CondE;
    it_len_sat = (bus.ItLenE > ITW'(IT_MAX)) ? ITW'(IT_MAX) : bus.ItLenE;
    cond_ex   = '0;
    reg_g     = '0;
    // the IT instruction itself never writes or branches
    for (int unsigned l = 0; l < LANES; l++) begin
      cond_ex[l] = cond_pass(cond_eff, flags_q[4*l +: 4]);
      reg_g[l]   = bus.RegWriteE & cond_ex[l] & ~bus.FlushE & ~bus.ItStartE;
    end
    mem_g = bus.MemWriteE & cond_ex[0] & ~bus.FlushE & ~bus.ItStartE;
    pc_g  = bus.PCSrcE    & cond_ex[0] & ~bus.FlushE & ~bus.ItStartE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= '0;
      it_count <= '0;
      it_mask  <= '0;
      it_cond  <= '0;
    end else begin
      if (advance) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (cond_ex[l]) begin
            if (bus.FlagWriteE[1]) flags_q[4*l+2 +: 2] <= bus.ALUFlagsE[4*l+2 +: 2];
            if (bus.FlagWriteE[0]) flags_q[4*l   +: 2] <= bus.ALUFlagsE[4*l   +: 2];
          end
        end
      end
      if (bus.FlushE) begin
        it_count <= '0;
        it_mask  <= '0;
      end else if (!bus.StallE) begin
        if (bus.ItStartE) begin
          it_cond  <= bus.ItCondE;
          it_mask  <= bus.ItMaskE;
          it_count <= it_len_sat;
        end else if (it_active && pc_g) begin
          it_count <= '0;
        end else if (it_active) begin
          it_count <= it_count - 1'b1;
          it_mask  <= it_mask >> 1;
        end
      end
    end
  end

  always_comb begin
    bus.CondExE     = cond_ex;
    bus.RegWriteGE  = reg_g;
    bus.MemWriteGE  = mem_g;
    bus.PCSrcGE     = pc_g;
    bus.FlagsQ      = flags_q;
    bus.ItActive    = it_active;
    bus.ItRemaining = it_count;
  end
endmodule

// File: tb/tb_condlogic_it.sv
// Directed bench for condlogic_it with two lanes and a 4-slot IT block.
module tb_condlogic_it;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;

  condlogic_it_if #(.LANES(2), .IT_MAX(4)) bus ();
  condlogic_it #(.LANES(2), .IT_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.StallE = 0; bus.FlushE = 0; bus.CondE = 4'b0000; bus.FlagWriteE = 2'b00;
    bus.ALUFlagsE = 8'h00; bus.RegWriteE = 0; bus.MemWriteE = 0; bus.PCSrcE = 0;
    bus.ItStartE = 0; bus.ItCondE = 4'b0000; bus.ItMaskE = 4'b0000; bus.ItLenE = 3'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    // T1 reset state and fixed codes
    check("rst_flags", bus.FlagsQ, 8'h00);
    check("rst_itact", bus.ItActive, 1'b0);
    check("rst_itrem", bus.ItRemaining, 3'd0);
    check("eq_z0", bus.CondExE, 2'b00);
    bus.CondE = 4'b1110; #1;
    check("al", bus.CondExE, 2'b11);
    bus.CondE = 4'b1111; #1;
    check("nv", bus.CondExE, 2'b00);

    // T2 compare sets Z; next instruction sees it
    bus.CondE = 4'b1110; bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 8'h44;
    tick();
    check("cmp_flags", bus.FlagsQ, 8'h44);
    bus.FlagWriteE = 2'b00; bus.CondE = 4'b0000; #1;
    check("cmp_eq", bus.CondExE, 2'b11);
    bus.CondE = 4'b1110; bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 8'h00;
    tick();
    bus.FlagWriteE = 2'b01; bus.ALUFlagsE = 8'h66;
    tick();
    check("cv_only_flags", bus.FlagsQ, 8'h22);
    bus.FlagWriteE = 2'b00; bus.CondE = 4'b0000; #1;
    check("cv_only_eq", bus.CondExE, 2'b00);
    bus.CondE = 4'b0010; #1;
    check("cv_only_cs", bus.CondExE, 2'b11);
    bus.CondE = 4'b1000; #1;
    check("hi", bus.CondExE, 2'b11);

    // N=1,V=0 in lane 0, N=0,V=0 in lane 1
    bus.CondE = 4'b1110; bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 8'h08;
    tick();
    bus.FlagWriteE = 2'b00; bus.CondE = 4'b1011; #1;
    check("lt", bus.CondExE, 2'b01);
    bus.CondE = 4'b1010; #1;
    check("ge", bus.CondExE, 2'b10);

    // T3 IT block EQ/NE/EQ with Z=1 in both lanes
    bus.CondE = 4'b1110; bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 8'h44;
    tick();
    bus.FlagWriteE = 2'b00; bus.RegWriteE = 1'b1;
    bus.ItStartE = 1; bus.ItCondE = 4'b0000; bus.ItMaskE = 4'b0101; bus.ItLenE = 3'd3;
    #1;
    check("it_instr_regwr", bus.RegWriteGE, 2'b00);
    tick();
    bus.ItStartE = 0; bus.CondE = 4'b1101; #1;
    check("it_s0_rem", bus.ItRemaining, 3'd3);
    check("it_s0_cond", bus.CondExE, 2'b11);
    tick();
    check("it_s1_rem", bus.ItRemaining, 3'd2);
    check("it_s1_cond", bus.CondExE, 2'b00);
    check("it_s1_regwr", bus.RegWriteGE, 2'b00);
    tick();
    check("it_s2_rem", bus.ItRemaining, 3'd1);
    check("it_s2_cond", bus.CondExE, 2'b11);
    tick();
    check("it_end_act", bus.ItActive, 1'b0);
    bus.CondE = 4'b0001; #1;
    check("it_end_cond", bus.CondExE, 2'b00);
    bus.RegWriteE = 1'b0;

    // ItLenE beyond IT_MAX saturates; then flush clears
    bus.ItStartE = 1; bus.ItMaskE = 4'b1111; bus.ItLenE = 3'd7;
    tick();
    bus.ItStartE = 0;
    check("it_len_sat", bus.ItRemaining, 3'd4);
    bus.FlushE = 1;
    tick();
    bus.FlushE = 0;
    check("flush_clear", bus.ItActive, 1'b0);
    bus.ItStartE = 1; bus.ItLenE = 3'd0;
    tick();
    bus.ItStartE = 0;
    check("it_len0", bus.ItActive, 1'b0);

    // T4 stall mid-IT, then stall+flush
    bus.ItStartE = 1; bus.ItCondE = 4'b0000; bus.ItMaskE = 4'b1111; bus.ItLenE = 3'd4;
    tick();
    bus.ItStartE = 0;
    tick();
    check("t4_rem", bus.ItRemaining, 3'd3);
    bus.StallE = 1; bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 8'h00;
    tick(); tick();
    check("stall_rem", bus.ItRemaining, 3'd3);
    check("stall_flags", bus.FlagsQ, 8'h44);
    bus.FlushE = 1;
    tick();
    check("stallflush_act", bus.ItActive, 1'b0);
    check("stallflush_flags", bus.FlagsQ, 8'h44);
    bus.StallE = 0; bus.FlushE = 0; bus.FlagWriteE = 2'b00;

    // T6 taken branch in slot 1 ends the block
    bus.ItStartE = 1; bus.ItLenE = 3'd4;
    tick();
    bus.ItStartE = 0;
    tick();
    bus.PCSrcE = 1; bus.MemWriteE = 1; #1;
    check("br_pcsrc", bus.PCSrcGE, 1'b1);
    check("br_memwr", bus.MemWriteGE, 1'b1);
    tick();
    bus.PCSrcE = 0; bus.MemWriteE = 0;
    check("br_itact", bus.ItActive, 1'b0);
    check("br_itrem", bus.ItRemaining, 3'd0);

    // T5 lanes evaluate against their own flags
    bus.CondE = 4'b1110; bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 8'h04;
    tick();
    bus.FlagWriteE = 2'b00; bus.CondE = 4'b0000; bus.RegWriteE = 1; bus.MemWriteE = 1; #1;
    check("lane_regwr01", bus.RegWriteGE, 2'b01);
    check("lane_memwr1", bus.MemWriteGE, 1'b1);
    bus.CondE = 4'b1110; bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 8'h40;
    tick();
    bus.FlagWriteE = 2'b00; bus.CondE = 4'b0000; #1;
    check("lane_regwr10", bus.RegWriteGE, 2'b10);
    check("lane_memwr0", bus.MemWriteGE, 1'b0);

    // flush squashes writes and flag updates
    bus.CondE = 4'b1110; bus.FlushE = 1; bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 8'hFF; #1;
    check("flush_regwr", bus.RegWriteGE, 2'b00);
    tick();
    check("flush_flags", bus.FlagsQ, 8'h40);
    bus.FlushE = 0; bus.FlagWriteE = 2'b00; bus.RegWriteE = 0; bus.MemWriteE = 0;

    // reset mid-IT
    bus.ItStartE = 1; bus.ItLenE = 3'd2;
    tick();
    bus.ItStartE = 0;
    check("pre_rst_rem", bus.ItRemaining, 3'd2);
    reset = 1;
    tick();
    reset = 0;
    check("midrst_rem", bus.ItRemaining, 3'd0);
    check("midrst_flags", bus.FlagsQ, 8'h00);
    bus.CondE = 4'b0000; #1;
    check("midrst_cond", bus.CondExE, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
